// File: rtl/refill_scheduler.sv
// refill_scheduler: round-robin owner of the single DDR burst master for the
// four cache ports. A granted port gets an optional dirty-victim write-back
// burst, then a line-fill read burst, then a one-cycle done pulse.
module refill_scheduler #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            wb,
    input  logic [4*ADDR_W-1:0]   fill_addr,
    input  logic [4*ADDR_W-1:0]   wb_addr,
    input  logic [4*DATA_W-1:0]   wb_data,
    output logic [3:0]            gnt,
    output logic [BEAT_W-1:0]     beat_idx,
    output logic                  fill_valid,
    output logic [DATA_W-1:0]     fill_data,
    output logic [3:0]            done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BEAT_W:0]       mem_burstcount,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic [DATA_W-1:0]     mem_readdata,
    input  logic                  mem_readdatavalid,
    output logic                  proto_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WAITD = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W:0]   BURST_CNT = (BEAT_W + 1)'(BURST_LEN);

    // Control state (reset)
    logic [2:0]          state_q, state_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          win_q, win_d;
    logic [1:0]          rr_q, rr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_q, last_d;
    logic                fill_valid_q, fill_valid_d;
    logic                proto_q, proto_d;

    // Datapath registers (no reset; qualified by control state)
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [BEAT_W-1:0]   fill_beat_q, fill_beat_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;

    logic                arb_found;
    logic [1:0]          arb_win;
    logic                wr_acc;
    logic                rd_acc;
    logic                rdv_acc;

    assign wr_acc  = (state_q == S_WB) && !mem_waitrequest;
    assign rd_acc  = (state_q == S_RD) && !mem_waitrequest;
    // Beats after the last one of the burst are not forwarded to the port.
    assign rdv_acc = (state_q == S_WAITD) && mem_readdatavalid && !last_q;

    // Round-robin pick: first requesting port at or after rr_q, cyclically.
    always_comb begin
        logic [1:0] idx;
        arb_found = 1'b0;
        arb_win   = rr_q;
        idx       = rr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
    end

    // Transaction sequencer: grant, write-back, fill command, fill beats, done.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        last_d  = last_q;
        faddr_d = faddr_q;
        waddr_d = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = 4'b0001 << arb_win;
                    win_d   = arb_win;
                    faddr_d = fill_addr[arb_win*ADDR_W +: ADDR_W];
                    waddr_d = wb_addr[arb_win*ADDR_W +: ADDR_W];
                    beat_d  = '0;
                    last_d  = 1'b0;
                    state_d = wb[arb_win] ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (wr_acc) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (rd_acc) begin
                    beat_d  = '0;
                    state_d = S_WAITD;
                end
            end
            S_WAITD: begin
                if (rdv_acc) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        last_d = 1'b1;
                    end
                end
                // last_q is set while the final fill beat is on the port,
                // so done lands on the cycle after it.
                if (last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                rr_d    = win_q + 2'd1;
                beat_d  = '0;
                last_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Fill beat capture and protocol-error detection.
    always_comb begin
        fill_valid_d = rdv_acc;
        fill_beat_d  = rdv_acc ? beat_q : fill_beat_q;
        fill_data_d  = rdv_acc ? mem_readdata : fill_data_q;
        proto_d      = proto_q | (mem_readdatavalid && (state_q != S_WAITD));
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            win_q        <= '0;
            rr_q         <= '0;
            beat_q       <= '0;
            last_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            proto_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            win_q        <= win_d;
            rr_q         <= rr_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            fill_valid_q <= fill_valid_d;
            proto_q      <= proto_d;
        end
    end

    // Address and fill data registers, gated at the outputs by control state.
    always_ff @(posedge clk) begin
        faddr_q     <= faddr_d;
        waddr_q     <= waddr_d;
        fill_beat_q <= fill_beat_d;
        fill_data_q <= fill_data_d;
    end

    // Output decode from registered state.
    always_comb begin
        gnt            = gnt_q;
        done           = (state_q == S_DONE) ? gnt_q : 4'b0000;
        mem_write      = (state_q == S_WB);
        mem_read       = (state_q == S_RD);
        mem_addr       = mem_write ? waddr_q : (mem_read ? faddr_q : '0);
        mem_burstcount = (mem_read || mem_write) ? BURST_CNT : '0;
        mem_writedata  = mem_write ? wb_data[win_q*DATA_W +: DATA_W] : '0;
        beat_idx       = fill_valid_q ? fill_beat_q : beat_q;
        fill_valid     = fill_valid_q;
        fill_data      = fill_data_q;
        proto_err      = proto_q;
    end

endmodule

// File: tb/tb_refill_scheduler.sv
// tb_refill_scheduler: directed stimulus with a scoreboard. The main process
// queues expected write beats, read commands, fill beats and done pulses; a
// monitor pops and compares whenever the DUT presents one. A bus process plays
// the four requesters and the DDR slave.
module tb_refill_scheduler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic                clk;
    logic                rst;
    logic [3:0]          req;
    logic [3:0]          wb;
    logic [4*ADDR_W-1:0] fill_addr;
    logic [4*ADDR_W-1:0] wb_addr;
    logic [4*DATA_W-1:0] wb_data;
    logic [3:0]          gnt;
    logic [1:0]          beat_idx;
    logic                fill_valid;
    logic [DATA_W-1:0]   fill_data;
    logic [3:0]          done;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read;
    logic                mem_write;
    logic [2:0]          mem_burstcount;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_waitrequest;
    logic [DATA_W-1:0]   mem_readdata;
    logic                mem_readdatavalid;
    logic                proto_err;

    refill_scheduler #(
        .ADDR_W(32), .DATA_W(128), .BURST_LEN(4), .BEAT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wb(wb),
        .fill_addr(fill_addr), .wb_addr(wb_addr), .wb_data(wb_data),
        .gnt(gnt), .beat_idx(beat_idx), .fill_valid(fill_valid),
        .fill_data(fill_data), .done(done), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_burstcount(mem_burstcount), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [255:0] wr_q[$];
    logic [255:0] rd_q[$];
    logic [255:0] fill_q[$];
    logic [255:0] done_q[$];

    // Written only by the main process
    int          issued [4];
    int          inj_cnt;
    int          rd_gap;
    logic [3:0]  stall_mask;
    logic [3:0]  drop_mask;
    // Written only by the bus process
    int          served [4];
    int          inj_done;
    int          stall_seen;

    assign fill_addr = {32'h0000_1300, 32'h0000_1200, 32'h0000_1100, 32'h0000_1000};
    assign wb_addr   = {32'h0000_3080, 32'h0000_2040, 32'h0000_3040, 32'h0000_3000};

    function automatic logic [127:0] rd_pat(input logic [31:0] a, input logic [1:0] k);
        return {a, 32'hF111_DA7A, 62'h0, k};
    endfunction

    function automatic logic [127:0] wbpat(input logic [3:0] p, input logic [1:0] k);
        return {28'hB0B0B0B, p, 94'h0, k};
    endfunction

    // Each port presents its victim beat selected by beat_idx
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            wb_data[p*DATA_W +: DATA_W] = wbpat(4'(p), beat_idx);
        end
    end

    function automatic logic [255:0] pk_wr(input logic [31:0] a, input logic [127:0] d,
                                           input logic [1:0] b, input logic [2:0] c);
        return 256'({a, d, b, c});
    endfunction

    function automatic logic [255:0] pk_rd(input logic [3:0] g, input logic [31:0] a,
                                           input logic [2:0] c);
        return 256'({g, a, c});
    endfunction

    function automatic logic [255:0] pk_fill(input logic [3:0] g, input logic [1:0] b,
                                             input logic [127:0] d);
        return 256'({g, b, d});
    endfunction

    function automatic logic [255:0] pk_done(input logic [3:0] d, input logic [3:0] g);
        return 256'({d, g});
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT presented an event with nothing expected", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_txn(input int p, input bit w);
        logic [3:0]  oh;
        logic [31:0] fa;
        logic [31:0] wa;
        oh = 4'(1) << p;
        fa = fill_addr[p*ADDR_W +: ADDR_W];
        wa = wb_addr[p*ADDR_W +: ADDR_W];
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                wr_q.push_back(pk_wr(wa, wbpat(4'(p), 2'(k)), 2'(k), 3'd4));
            end
        end
        rd_q.push_back(pk_rd(oh, fa, 3'd4));
        for (int k = 0; k < 4; k++) begin
            fill_q.push_back(pk_fill(oh, 2'(k), rd_pat(fa, 2'(k))));
        end
        done_q.push_back(pk_done(oh, oh));
    endtask

    function automatic bit quiet();
        bit q;
        q = (wr_q.size() == 0) && (rd_q.size() == 0) && (fill_q.size() == 0)
            && (done_q.size() == 0) && (gnt == 4'b0000);
        for (int i = 0; i < 4; i++) begin
            if (issued[i] != served[i]) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!quiet()) begin
            failures++;
            $display("FAIL %s: not complete after %0d cycles, done pending=%0d fills pending=%0d",
                     name, n, done_q.size(), fill_q.size());
        end
    endtask

    // Requesters and DDR slave, driven on the falling edge
    initial begin
        logic [3:0]  cool;
        logic [3:0]  stalled;
        int          rd_cnt;
        int          gap_cnt;
        logic [1:0]  rd_beat;
        logic [31:0] rd_addr;
        req = '0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata = '0;
        for (int i = 0; i < 4; i++) served[i] = 0;
        inj_done = 0;
        stall_seen = 0;
        cool = '0;
        stalled = '0;
        rd_cnt = 0;
        gap_cnt = 0;
        rd_beat = '0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (done[i]) begin
                    served[i]++;
                    req[i] = 1'b0;
                    cool[i] = 1'b1;
                end else if (cool[i]) begin
                    cool[i] = 1'b0;
                end else begin
                    req[i] = (issued[i] != served[i]) && !drop_mask[i];
                end
            end
            mem_waitrequest = 1'b0;
            if (!mem_write) begin
                stalled = '0;
            end else if (stall_mask[beat_idx] && !stalled[beat_idx]) begin
                mem_waitrequest = 1'b1;
                stalled[beat_idx] = 1'b1;
                stall_seen++;
            end
            mem_readdatavalid = 1'b0;
            if (inj_cnt != inj_done) begin
                inj_done++;
                mem_readdatavalid = 1'b1;
                mem_readdata = '1;
            end else if (rd_cnt > 0) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = rd_pat(rd_addr, rd_beat);
                    rd_beat++;
                    rd_cnt--;
                    gap_cnt = rd_gap;
                end
            end
            if (mem_read && !mem_waitrequest) begin
                rd_cnt = 4;
                rd_beat = '0;
                rd_addr = mem_addr;
                gap_cnt = rd_gap;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_write && !mem_waitrequest) begin
                if (wr_q.size() == 0) unexpected("wr_beat");
                else chk("wr_beat", pk_wr(mem_addr, mem_writedata, beat_idx, mem_burstcount),
                         wr_q.pop_front());
            end
            if (mem_read && !mem_waitrequest) begin
                chk("rd_after_wb", 256'(wr_q.size()), 256'(0));
                if (rd_q.size() == 0) unexpected("rd_cmd");
                else chk("rd_cmd", pk_rd(gnt, mem_addr, mem_burstcount), rd_q.pop_front());
            end
            if (fill_valid) begin
                if (fill_q.size() == 0) unexpected("fill_beat");
                else chk("fill_beat", pk_fill(gnt, beat_idx, fill_data), fill_q.pop_front());
            end
            if (done != 4'b0000) begin
                if (done_q.size() == 0) unexpected("done");
                else chk("done", pk_done(done, gnt), done_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed test sequence
    initial begin
        int n;
        int st0;
        rst = 1'b1;
        wb = '0;
        stall_mask = '0;
        drop_mask = '0;
        rd_gap = 0;
        inj_cnt = 0;
        for (int i = 0; i < 4; i++) issued[i] = 0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt", 256'(gnt), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_fill_valid", 256'(fill_valid), 256'(0));
        chk("rst_mem_read", 256'(mem_read), 256'(0));
        chk("rst_mem_write", 256'(mem_write), 256'(0));
        chk("rst_burstcount", 256'(mem_burstcount), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_proto_err", 256'(proto_err), 256'(0));
        rst = 1'b0;
        tick();
        chk("idle_gnt", 256'(gnt), 256'(0));

        // Single fill on port 0, no write-back, zero wait
        rd_q.push_back(pk_rd(4'b0001, 32'h0000_1000, 3'd4));
        for (int k = 0; k < 4; k++) begin
            fill_q.push_back(pk_fill(4'b0001, 2'(k),
                             128'h00001000_F111DA7A_00000000_00000000 | 128'(k)));
        end
        done_q.push_back(pk_done(4'b0001, 4'b0001));
        issued[0]++;
        tick();
        chk("t1_gnt_before", 256'(gnt), 256'(0));
        tick();
        chk("t1_gnt", 256'(gnt), 256'(4'b0001));
        chk("t1_mem_read", 256'(mem_read), 256'(1));
        chk("t1_mem_addr", 256'(mem_addr), 256'(32'h0000_1000));
        chk("t1_burstcount", 256'(mem_burstcount), 256'(4));
        wait_quiet(100, "t1_complete");
        chk("t1_gnt_after", 256'(gnt), 256'(0));
        chk("t1_mem_read_after", 256'(mem_read), 256'(0));

        // All four ports requesting: rotation 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_gap = 1;
        push_txn(0, 1'b0);
        push_txn(1, 1'b0);
        push_txn(2, 1'b0);
        push_txn(3, 1'b0);
        push_txn(0, 1'b0);
        issued[0] += 2;
        issued[1]++;
        issued[2]++;
        issued[3]++;
        wait_quiet(400, "rr_complete");

        // Read-data-valid while idle
        inj_cnt++;
        tick();
        tick();
        chk("proto_set", 256'(proto_err), 256'(1));
        chk("proto_no_fill", 256'(fill_valid), 256'(0));
        tick();
        chk("proto_sticky", 256'(proto_err), 256'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("proto_cleared", 256'(proto_err), 256'(0));

        // Port 2 write-back with stalls on beats 1 and 3
        st0 = stall_seen;
        stall_mask = 4'b1010;
        rd_gap = 0;
        wb = 4'b0100;
        push_txn(2, 1'b1);
        issued[2]++;
        wait_quiet(100, "wb_complete");
        chk("wb_stall_cycles", 256'(stall_seen - st0), 256'(2));
        stall_mask = '0;
        wb = '0;

        // Reset in the middle of a write-back burst
        wb = 4'b0100;
        push_txn(2, 1'b1);
        issued[2]++;
        n = 0;
        while (!(mem_write && beat_idx == 2'd2) && n < 50) begin
            tick();
            n++;
        end
        chk("rstwb_reach_beat2", 256'({mem_write, beat_idx}), 256'({1'b1, 2'd2}));
        rst = 1'b1;
        tick();
        chk("rstwb_outputs", 256'({gnt, done, fill_valid, mem_read, mem_write,
                                   mem_burstcount, mem_addr, proto_err}), 256'(0));
        wr_q.delete();
        rd_q.delete();
        fill_q.delete();
        done_q.delete();
        push_txn(2, 1'b1);
        rst = 1'b0;
        tick();
        chk("rstwb_regnt", 256'(gnt), 256'(4'b0100));
        chk("rstwb_beat0", 256'(beat_idx), 256'(0));
        chk("rstwb_write", 256'(mem_write), 256'(1));
        chk("rstwb_addr", 256'(mem_addr), 256'(32'h0000_2040));
        wait_quiet(100, "rstwb_complete");
        wb = '0;

        // Port 0 drops req during the fill; transaction still completes
        rd_gap = 1;
        push_txn(0, 1'b0);
        issued[0]++;
        n = 0;
        while (!fill_valid && n < 50) begin
            tick();
            n++;
        end
        chk("drop_first_fill", 256'(fill_valid), 256'(1));
        drop_mask = 4'b0001;
        wait_quiet(100, "drop_complete");
        drop_mask = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
